tcp_rx_ptr_if_requester: RTL and testbench
==========================================

// Module: tcp_rx_ptr_if_requester
// PURPOSE
//  App-side initiator for the TCP RX pointer interface tile, one per app tile.
//  Turns app head-pointer writes and pointer reads into single-flit NoC requests.
//  Blocks until the matching TCP_RX_PTRS_RESP flit returns, then hands head/commit ptrs to the app.
//  Allows at most one outstanding read.
// PARAMETERS
//  FLOWID_W     8                 flow id width
//  RX_PTR_W     32                head/commit pointer width; payload stores it as-is, no wrap arithmetic
//  NOC_DATA_W   `NOC_DATA_WIDTH   NoC flit width
// PORTS
//  clk                      in   1           clock
//  rst                      in   1           synchronous, active-high reset
//  src_x, src_y             in   XY_WIDTH    this tile's coordinates, carried in the request header
//  dst_x, dst_y             in   XY_WIDTH    RX pointer tile's coordinates
//  app_wr_req_val           in   1           head ptr write request
//  app_wr_req_flowid        in   FLOWID_W    flow to update
//  app_wr_req_head_ptr      in   RX_PTR_W    new head ptr
//  app_wr_req_rdy           out  1           write accepted
//  app_rd_req_val           in   1           ptr read request
//  app_rd_req_flowid        in   FLOWID_W    flow to read
//  app_rd_req_rdy           out  1           read accepted
//  app_rd_resp_val          out  1           ptrs valid
//  app_rd_resp_head_ptr     out  RX_PTR_W    returned head ptr
//  app_rd_resp_commit_ptr   out  RX_PTR_W    returned commit ptr
//  app_rd_resp_rdy          in   1           app takes ptrs
//  noc0_vrtoc_val           out  1           request flit valid
//  noc0_vrtoc_data          out  NOC_DATA_W  request flit
//  noc0_vrtoc_rdy           in   1           NoC accepts flit
//  noc0_ctovr_val           in   1           incoming flit valid
//  noc0_ctovr_data          in   NOC_DATA_W  incoming flit
//  noc0_ctovr_rdy           out  1           flit consumed
//  err_unexp_flit           out  1           sticky: an unexpected flit was dropped; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; all val/rdy outputs 0 while rst=1; err_unexp_flit=0; data regs 0.
//  FSM states: IDLE, SEND_WR, SEND_RD, WAIT_RESP, RESP_OUT.
//  IDLE
//   - app_wr_req_rdy=1 and app_rd_req_rdy=1 (both only in IDLE); noc0_ctovr_rdy=1.
//   - If both app requests are valid, the write wins; the read stays pending (val held).
//   - On write accept: latch flowid and head ptr -> SEND_WR.
//   - On read accept: latch flowid -> SEND_RD.
//   - Any ctovr flit arriving in IDLE is consumed, dropped and sets err_unexp_flit.
//  SEND_WR
//   - noc0_vrtoc_val=1, msg_type=TCP_RX_HEAD_PTR_WR, msg_len=0, flowid and head ptr in the payload.
//   - On vrtoc_rdy -> IDLE. No response is expected.
//  SEND_RD
//   - noc0_vrtoc_val=1, msg_type=TCP_RX_PTRS_REQ, msg_len=0, flowid in the payload.
//   - On vrtoc_rdy -> WAIT_RESP.
//  WAIT_RESP
//   - noc0_ctovr_rdy=1.
//   - On a flit with msg_type==TCP_RX_PTRS_RESP and flowid==latched flowid: latch head and commit ptrs -> RESP_OUT.
//   - Any other flit is dropped, sets err_unexp_flit, and the FSM stays in WAIT_RESP.
//  RESP_OUT
//   - app_rd_resp_val=1; the ptrs stay stable until app_rd_resp_rdy -> IDLE.
//  Outside IDLE and WAIT_RESP, noc0_ctovr_rdy=0.
//  Latency
//   - App accept in cycle N gives vrtoc_val in cycle N+1; vrtoc_data is registered and holds under backpressure.
//   - Response flit accepted in cycle M gives app_rd_resp_val in cycle M+1.
//  Reset mid-operation aborts any request or read.
//   - A late response then arrives in IDLE, is dropped, and sets err_unexp_flit.
//   - The ctovr link is never blocked.
//  Header fields: dst = dst_x/dst_y; src = src_x/src_y; fbits = TCP_RX_PTR_IF fbits; every other field 0.
// STRUCTURE
//  tcp_rx_ptr_if_pkg (shared with the responder tile):
//   - msg types TCP_RX_PTRS_REQ, TCP_RX_PTRS_RESP, TCP_RX_HEAD_PTR_WR.
//   - packed structs tcp_rx_ptr_req_flit {beehive_noc_hdr_flit-compatible header, flowid, head_ptr, pad}.
//   - packed structs tcp_rx_ptr_resp_flit {header, flowid, head_ptr, commit_ptr, pad}.
//  Control/datapath split:
//   - this module holds the FSM.
//   - sub-module tcp_rx_ptr_if_requester_datap holds the latched request fields, flit packing/unpacking,
//     the flowid compare and the ptr registers, driven by store_req / store_resp strobes.
// TESTING
//  1. Write, no backpressure: wr flowid=5, head=0x100 -> one flit, TCP_RX_HEAD_PTR_WR, flowid=5, head=0x100 at N+1; rdy back at N+2.
//  2. Read round trip: rd flowid=3; responder returns RESP flowid=3, head=0x40, commit=0x80 -> app_rd_resp_val with 0x40/0x80 one cycle later.
//  3. Simultaneous wr flowid=1 and rd flowid=2 -> the write flit goes first; the read is accepted only after IDLE is re-entered.
//  4. vrtoc_rdy held 0 for 10 cycles -> val and data stable throughout; exactly one flit is sent.
//  5. In WAIT_RESP, inject RESP flowid=9 for outstanding flowid=3 -> dropped, err=1, FSM still waits; correct flit completes the read.
//  6. Assert rst in WAIT_RESP, then deliver the response -> consumed in IDLE, err=1, app_rd_resp_val stays 0.

Source files
------------

// File: rtl/tcp_rx_ptr_if_pkg.sv
// Shared definitions for the TCP RX pointer interface: message types, flit layouts and
// the requester FSM state type.
package tcp_rx_ptr_if_pkg;

  localparam int unsigned TCP_FLOWID_W   = 8;
  localparam int unsigned TCP_RX_PTR_W   = 32;
  localparam int unsigned TCP_NOC_DATA_W = 256;
  localparam int unsigned XY_WIDTH       = 8;
  localparam int unsigned FBITS_W        = 4;
  localparam int unsigned MSG_LEN_W      = 8;
  localparam int unsigned MSG_TYPE_W     = 8;
  localparam int unsigned HDR_W          = 64;
  localparam int unsigned HDR_PAD_W      = HDR_W - 4 * XY_WIDTH - 2 * FBITS_W - MSG_LEN_W -
                                           MSG_TYPE_W;

  localparam logic [FBITS_W-1:0] TCP_RX_PTR_IF_FBITS = 4'b1010;

  typedef enum logic [MSG_TYPE_W-1:0] {
    TCP_RX_PTRS_REQ    = 8'h30,
    TCP_RX_PTRS_RESP   = 8'h31,
    TCP_RX_HEAD_PTR_WR = 8'h32
  } tcp_rx_ptr_msg_e;

  // Field order matches the beehive NoC header flit, MSB first.
  typedef struct packed {
    logic [XY_WIDTH-1:0]   dst_x;
    logic [XY_WIDTH-1:0]   dst_y;
    logic [FBITS_W-1:0]    dst_fbits;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [XY_WIDTH-1:0]   src_x;
    logic [XY_WIDTH-1:0]   src_y;
    logic [FBITS_W-1:0]    src_fbits;
    logic [HDR_PAD_W-1:0]  pad;
  } noc_hdr_flit_t;

  typedef struct packed {
    noc_hdr_flit_t                                          hdr;
    logic [TCP_FLOWID_W-1:0]                                flowid;
    logic [TCP_RX_PTR_W-1:0]                                head_ptr;
    logic [TCP_NOC_DATA_W-HDR_W-TCP_FLOWID_W-TCP_RX_PTR_W-1:0] pad;
  } tcp_rx_ptr_req_flit;

  typedef struct packed {
    noc_hdr_flit_t                                            hdr;
    logic [TCP_FLOWID_W-1:0]                                  flowid;
    logic [TCP_RX_PTR_W-1:0]                                  head_ptr;
    logic [TCP_RX_PTR_W-1:0]                                  commit_ptr;
    logic [TCP_NOC_DATA_W-HDR_W-TCP_FLOWID_W-2*TCP_RX_PTR_W-1:0] pad;
  } tcp_rx_ptr_resp_flit;

  typedef enum logic [2:0] {
    StIdle,
    StSendWr,
    StSendRd,
    StWaitResp,
    StRespOut
  } req_state_e;

endpackage

// File: rtl/tcp_rx_ptr_if_requester_datap.sv
// Requester datapath: latched request fields, request flit register, response unpacking,
// flowid match and returned pointer registers.
module tcp_rx_ptr_if_requester_datap
  import tcp_rx_ptr_if_pkg::*;
#(
  parameter int unsigned FLOWID_W   = TCP_FLOWID_W,
  parameter int unsigned RX_PTR_W   = TCP_RX_PTR_W,
  parameter int unsigned NOC_DATA_W = TCP_NOC_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XY_WIDTH-1:0]   src_x,
  input  logic [XY_WIDTH-1:0]   src_y,
  input  logic [XY_WIDTH-1:0]   dst_x,
  input  logic [XY_WIDTH-1:0]   dst_y,
  input  logic                  store_req,
  input  logic                  req_is_wr,
  input  logic [FLOWID_W-1:0]   req_flowid,
  input  logic [RX_PTR_W-1:0]   req_head_ptr,
  input  logic                  store_resp,
  input  logic [NOC_DATA_W-1:0] ctovr_data,
  output logic                  resp_match,
  output logic [NOC_DATA_W-1:0] vrtoc_data,
  output logic [RX_PTR_W-1:0]   resp_head_ptr,
  output logic [RX_PTR_W-1:0]   resp_commit_ptr
);

  tcp_rx_ptr_req_flit  req_flit_d, req_flit_q;
  tcp_rx_ptr_resp_flit in_flit;
  logic [FLOWID_W-1:0] flowid_q;
  logic [RX_PTR_W-1:0] head_q, commit_q;
  logic                unused_flit_bits;

  always_comb begin
    req_flit_d                = '0;
    req_flit_d.hdr.dst_x      = dst_x;
    req_flit_d.hdr.dst_y      = dst_y;
    req_flit_d.hdr.dst_fbits  = TCP_RX_PTR_IF_FBITS;
    req_flit_d.hdr.msg_type   = req_is_wr ? TCP_RX_HEAD_PTR_WR : TCP_RX_PTRS_REQ;
    req_flit_d.hdr.src_x      = src_x;
    req_flit_d.hdr.src_y      = src_y;
    req_flit_d.flowid         = req_flowid;
    req_flit_d.head_ptr       = req_is_wr ? req_head_ptr : '0;
  end

  assign in_flit    = ctovr_data;
  assign resp_match = (in_flit.hdr.msg_type == TCP_RX_PTRS_RESP) && (in_flit.flowid == flowid_q);
  // Routing fields of the response are not needed once it has reached this tile.
  assign unused_flit_bits = ^{in_flit.hdr, in_flit.pad};

  always_ff @(posedge clk) begin
    if (rst) begin
      req_flit_q <= '0;
      flowid_q   <= '0;
      head_q     <= '0;
      commit_q   <= '0;
    end else begin
      if (store_req) begin
        req_flit_q <= req_flit_d;
        flowid_q   <= req_flowid;
      end
      if (store_resp) begin
        head_q   <= in_flit.head_ptr;
        commit_q <= in_flit.commit_ptr;
      end
    end
  end

  assign vrtoc_data      = req_flit_q;
  assign resp_head_ptr   = head_q;
  assign resp_commit_ptr = commit_q;

endmodule

// File: rtl/tcp_rx_ptr_if_requester.sv
// App-side initiator for the TCP RX pointer tile: turns head-pointer writes and pointer reads
// into single-flit NoC requests, with at most one read outstanding.
module tcp_rx_ptr_if_requester
  import tcp_rx_ptr_if_pkg::*;
#(
  parameter int unsigned FLOWID_W   = TCP_FLOWID_W,
  parameter int unsigned RX_PTR_W   = TCP_RX_PTR_W,
  parameter int unsigned NOC_DATA_W = TCP_NOC_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XY_WIDTH-1:0]   src_x,
  input  logic [XY_WIDTH-1:0]   src_y,
  input  logic [XY_WIDTH-1:0]   dst_x,
  input  logic [XY_WIDTH-1:0]   dst_y,
  input  logic                  app_wr_req_val,
  input  logic [FLOWID_W-1:0]   app_wr_req_flowid,
  input  logic [RX_PTR_W-1:0]   app_wr_req_head_ptr,
  output logic                  app_wr_req_rdy,
  input  logic                  app_rd_req_val,
  input  logic [FLOWID_W-1:0]   app_rd_req_flowid,
  output logic                  app_rd_req_rdy,
  output logic                  app_rd_resp_val,
  output logic [RX_PTR_W-1:0]   app_rd_resp_head_ptr,
  output logic [RX_PTR_W-1:0]   app_rd_resp_commit_ptr,
  input  logic                  app_rd_resp_rdy,
  output logic                  noc0_vrtoc_val,
  output logic [NOC_DATA_W-1:0] noc0_vrtoc_data,
  input  logic                  noc0_vrtoc_rdy,
  input  logic                  noc0_ctovr_val,
  input  logic [NOC_DATA_W-1:0] noc0_ctovr_data,
  output logic                  noc0_ctovr_rdy,
  output logic                  err_unexp_flit
);

  req_state_e state_q;
  logic       err_q;
  logic       in_idle, in_wait;
  logic       store_req, store_resp, resp_match, ctovr_fire;

  assign in_idle = (state_q == StIdle);
  assign in_wait = (state_q == StWaitResp);

  // Handshakes are gated by rst so nothing is offered or accepted while reset is held.
  assign app_wr_req_rdy  = ~rst & in_idle;
  // A concurrent write wins, so the read must not see a completed handshake that cycle.
  assign app_rd_req_rdy  = ~rst & in_idle & ~app_wr_req_val;
  assign noc0_ctovr_rdy  = ~rst & (in_idle | in_wait);
  assign noc0_vrtoc_val  = ~rst & ((state_q == StSendWr) | (state_q == StSendRd));
  assign app_rd_resp_val = ~rst & (state_q == StRespOut);
  assign err_unexp_flit  = err_q;

  assign ctovr_fire = noc0_ctovr_val & noc0_ctovr_rdy;
  assign store_req  = ~rst & in_idle & (app_wr_req_val | app_rd_req_val);
  assign store_resp = in_wait & ctovr_fire & resp_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (app_wr_req_val)      state_q <= StSendWr;
          else if (app_rd_req_val) state_q <= StSendRd;
          if (ctovr_fire) err_q <= 1'b1;
        end
        StSendWr: if (noc0_vrtoc_rdy) state_q <= StIdle;
        StSendRd: if (noc0_vrtoc_rdy) state_q <= StWaitResp;
        StWaitResp: begin
          if (ctovr_fire) begin
            if (resp_match) state_q <= StRespOut;
            else            err_q   <= 1'b1;
          end
        end
        StRespOut: if (app_rd_resp_rdy) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  tcp_rx_ptr_if_requester_datap #(
    .FLOWID_W  (FLOWID_W),
    .RX_PTR_W  (RX_PTR_W),
    .NOC_DATA_W(NOC_DATA_W)
  ) u_datap (
    .clk            (clk),
    .rst            (rst),
    .src_x          (src_x),
    .src_y          (src_y),
    .dst_x          (dst_x),
    .dst_y          (dst_y),
    .store_req      (store_req),
    .req_is_wr      (app_wr_req_val),
    .req_flowid     (app_wr_req_val ? app_wr_req_flowid : app_rd_req_flowid),
    .req_head_ptr   (app_wr_req_head_ptr),
    .store_resp     (store_resp),
    .ctovr_data     (noc0_ctovr_data),
    .resp_match     (resp_match),
    .vrtoc_data     (noc0_vrtoc_data),
    .resp_head_ptr  (app_rd_resp_head_ptr),
    .resp_commit_ptr(app_rd_resp_commit_ptr)
  );

endmodule

// File: tb/tb_tcp_rx_ptr_if_requester.sv
// Scoreboard bench for tcp_rx_ptr_if_requester: expected flits and read responses are queued
// when stimulus is issued and popped by a negedge monitor on every completed handshake.
module tb_tcp_rx_ptr_if_requester;
  import tcp_rx_ptr_if_pkg::*;

  localparam int unsigned W = TCP_NOC_DATA_W;
  localparam logic [7:0] SX = 8'h12, SY = 8'h34, DX = 8'h56, DY = 8'h78;

  logic         clk, rst;
  logic [7:0]   src_x, src_y, dst_x, dst_y;
  logic         app_wr_req_val, app_wr_req_rdy;
  logic [7:0]   app_wr_req_flowid;
  logic [31:0]  app_wr_req_head_ptr;
  logic         app_rd_req_val, app_rd_req_rdy;
  logic [7:0]   app_rd_req_flowid;
  logic         app_rd_resp_val, app_rd_resp_rdy;
  logic [31:0]  app_rd_resp_head_ptr, app_rd_resp_commit_ptr;
  logic         noc0_vrtoc_val, noc0_vrtoc_rdy;
  logic [W-1:0] noc0_vrtoc_data;
  logic         noc0_ctovr_val, noc0_ctovr_rdy;
  logic [W-1:0] noc0_ctovr_data;
  logic         err_unexp_flit;

  tcp_rx_ptr_if_requester dut (
    .clk                   (clk),
    .rst                   (rst),
    .src_x                 (src_x),
    .src_y                 (src_y),
    .dst_x                 (dst_x),
    .dst_y                 (dst_y),
    .app_wr_req_val        (app_wr_req_val),
    .app_wr_req_flowid     (app_wr_req_flowid),
    .app_wr_req_head_ptr   (app_wr_req_head_ptr),
    .app_wr_req_rdy        (app_wr_req_rdy),
    .app_rd_req_val        (app_rd_req_val),
    .app_rd_req_flowid     (app_rd_req_flowid),
    .app_rd_req_rdy        (app_rd_req_rdy),
    .app_rd_resp_val       (app_rd_resp_val),
    .app_rd_resp_head_ptr  (app_rd_resp_head_ptr),
    .app_rd_resp_commit_ptr(app_rd_resp_commit_ptr),
    .app_rd_resp_rdy       (app_rd_resp_rdy),
    .noc0_vrtoc_val        (noc0_vrtoc_val),
    .noc0_vrtoc_data       (noc0_vrtoc_data),
    .noc0_vrtoc_rdy        (noc0_vrtoc_rdy),
    .noc0_ctovr_val        (noc0_ctovr_val),
    .noc0_ctovr_data       (noc0_ctovr_data),
    .noc0_ctovr_rdy        (noc0_ctovr_rdy),
    .err_unexp_flit        (err_unexp_flit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int flits_sent = 0;
  int resps_seen = 0;
  int bp_mode = 0;    // 0: always ready, 1: random, 2: stalled
  int rr_mode = 0;    // 0: app always takes ptrs, 1: random
  logic [W-1:0]  exp_flit_q[$];
  logic [63:0]   exp_resp_q[$];

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected handshake", name);
  endtask

  // Reference flit images written straight from the header layout, MSB first.
  function automatic logic [W-1:0] req_flit(input logic [7:0] mt, input logic [7:0] f,
                                            input logic [31:0] h);
    return {DX, DY, 4'b1010, 8'd0, mt, SX, SY, 4'd0, 8'd0, f, h, 152'd0};
  endfunction

  function automatic logic [W-1:0] resp_flit(input logic [7:0] mt, input logic [7:0] f,
                                             input logic [31:0] h, input logic [31:0] c);
    return {SX, SY, 4'd0, 8'd0, mt, DX, DY, 4'b1010, 8'd0, f, h, c, 120'd0};
  endfunction

  // Monitor: scoreboard pops plus a hold check on the request flit under backpressure.
  initial begin
    logic         hold_pend;
    logic [W-1:0] hold_data;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        chk1("vrtoc_hold_val", noc0_vrtoc_val, 1'b1);
        chk_w("vrtoc_hold_data", noc0_vrtoc_data, hold_data);
      end
      if (noc0_vrtoc_val && noc0_vrtoc_rdy) begin
        if (exp_flit_q.size() == 0) fail_timeout("vrtoc_unexpected_flit");
        else chk_w("vrtoc_flit", noc0_vrtoc_data, exp_flit_q.pop_front());
        flits_sent++;
      end
      if (app_rd_resp_val && app_rd_resp_rdy) begin
        if (exp_resp_q.size() == 0) fail_timeout("rd_resp_unexpected");
        else chk64("rd_resp_ptrs", {app_rd_resp_head_ptr, app_rd_resp_commit_ptr},
                   exp_resp_q.pop_front());
        resps_seen++;
      end
      hold_pend = noc0_vrtoc_val && !noc0_vrtoc_rdy;
      hold_data = noc0_vrtoc_data;
    end
  end

  initial begin
    noc0_vrtoc_rdy  = 1'b1;
    app_rd_resp_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      noc0_vrtoc_rdy  = (bp_mode == 0) ? 1'b1 :
                        (bp_mode == 1) ? ($urandom_range(3) != 0) : 1'b0;
      app_rd_resp_rdy = (rr_mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(output bit rd_rdy_seen);
    rd_rdy_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (app_wr_req_rdy) begin
        rd_rdy_seen = app_rd_req_rdy;
        return;
      end
    end
    fail_timeout("wr_accept");
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (app_rd_req_rdy) return;
    end
    fail_timeout("rd_accept");
  endtask

  task automatic wait_flits(input int target);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (flits_sent >= target) return;
    end
    fail_timeout("flit_sent");
  endtask

  task automatic wait_resps(input int target);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (resps_seen >= target) return;
    end
    fail_timeout("rd_resp");
  endtask

  task automatic send_ctovr(input logic [W-1:0] d);
    noc0_ctovr_val  = 1'b1;
    noc0_ctovr_data = d;
    for (int i = 0; i <= 500; i++) begin
      @(negedge clk);
      if (noc0_ctovr_rdy) break;
      if (i == 500) fail_timeout("ctovr_accept");
    end
    tick();
    noc0_ctovr_val = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] f, input logic [31:0] h);
    bit dummy;
    exp_flit_q.push_back(req_flit(TCP_RX_HEAD_PTR_WR, f, h));
    app_wr_req_val      = 1'b1;
    app_wr_req_flowid   = f;
    app_wr_req_head_ptr = h;
    wait_wr(dummy);
    tick();
    app_wr_req_val = 1'b0;
    @(negedge clk);
    chk1("wr_vrtoc_val_next_cycle", noc0_vrtoc_val, 1'b1);
    tick();
  endtask

  // Completes an accepted read whose request flit is the target-th one sent.
  task automatic finish_read(input logic [7:0] f, input logic [31:0] h, input logic [31:0] c,
                             input int target);
    int rtarget;
    wait_flits(target);
    tick();
    rtarget = resps_seen + 1;
    exp_resp_q.push_back({h, c});
    send_ctovr(resp_flit(TCP_RX_PTRS_RESP, f, h, c));
    @(negedge clk);
    chk1("rd_resp_val_next_cycle", app_rd_resp_val, 1'b1);
    wait_resps(rtarget);
    tick();
  endtask

  task automatic issue_read(input logic [7:0] f, output int target);
    exp_flit_q.push_back(req_flit(TCP_RX_PTRS_REQ, f, 32'd0));
    target            = flits_sent + exp_flit_q.size();
    app_rd_req_val    = 1'b1;
    app_rd_req_flowid = f;
    wait_rd();
    tick();
    app_rd_req_val = 1'b0;
    @(negedge clk);
    chk1("rd_vrtoc_val_next_cycle", noc0_vrtoc_val, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int   tgt, start;
    bit   rd_rdy_seen;
    logic [7:0]  f;
    logic [31:0] h, c;

    rst = 1'b1;
    src_x = SX; src_y = SY; dst_x = DX; dst_y = DY;
    app_wr_req_val = 0; app_wr_req_flowid = 0; app_wr_req_head_ptr = 0;
    app_rd_req_val = 0; app_rd_req_flowid = 0;
    noc0_ctovr_val = 0; noc0_ctovr_data = '0;
    tick();
    tick();
    @(negedge clk);
    chk1("rst_wr_rdy", app_wr_req_rdy, 1'b0);
    chk1("rst_rd_rdy", app_rd_req_rdy, 1'b0);
    chk1("rst_ctovr_rdy", noc0_ctovr_rdy, 1'b0);
    chk1("rst_vrtoc_val", noc0_vrtoc_val, 1'b0);
    chk1("rst_resp_val", app_rd_resp_val, 1'b0);
    chk1("rst_err", err_unexp_flit, 1'b0);
    chk_w("rst_vrtoc_data", noc0_vrtoc_data, '0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk1("idle_wr_rdy", app_wr_req_rdy, 1'b1);
    chk1("idle_ctovr_rdy", noc0_ctovr_rdy, 1'b1);
    tick();

    // 1: write, no backpressure, rdy returns two cycles after accept.
    exp_flit_q.push_back(req_flit(TCP_RX_HEAD_PTR_WR, 8'd5, 32'h100));
    app_wr_req_val = 1'b1; app_wr_req_flowid = 8'd5; app_wr_req_head_ptr = 32'h100;
    wait_wr(rd_rdy_seen);
    tick();
    app_wr_req_val = 1'b0;
    @(negedge clk);
    chk1("t1_vrtoc_val_n1", noc0_vrtoc_val, 1'b1);
    chk1("t1_wr_rdy_n1", app_wr_req_rdy, 1'b0);
    tick();
    @(negedge clk);
    chk1("t1_wr_rdy_n2", app_wr_req_rdy, 1'b1);
    chk1("t1_vrtoc_val_n2", noc0_vrtoc_val, 1'b0);
    tick();

    // 2: read round trip.
    issue_read(8'd3, tgt);
    finish_read(8'd3, 32'h40, 32'h80, tgt);

    // 3: simultaneous write and read; write flit first, read held off.
    exp_flit_q.push_back(req_flit(TCP_RX_HEAD_PTR_WR, 8'd1, 32'hABCD));
    exp_flit_q.push_back(req_flit(TCP_RX_PTRS_REQ, 8'd2, 32'd0));
    tgt = flits_sent + 2;
    app_wr_req_val = 1'b1; app_wr_req_flowid = 8'd1; app_wr_req_head_ptr = 32'hABCD;
    app_rd_req_val = 1'b1; app_rd_req_flowid = 8'd2;
    wait_wr(rd_rdy_seen);
    chk1("t3_rd_rdy_while_wr", rd_rdy_seen, 1'b0);
    tick();
    app_wr_req_val = 1'b0;
    wait_rd();
    tick();
    app_rd_req_val = 1'b0;
    finish_read(8'd2, 32'h1234_5678, 32'h9ABC_DEF0, tgt);

    // 4: request held under 10 cycles of backpressure; exactly one flit leaves.
    bp_mode = 2;
    tick();
    tick();
    start = flits_sent;
    do_write(8'd7, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) tick();
    chk64("t4_no_flit_stalled", 64'(flits_sent), 64'(start));
    bp_mode = 0;
    wait_flits(start + 1);
    for (int i = 0; i < 4; i++) tick();
    chk64("t4_one_flit", 64'(flits_sent), 64'(start + 1));

    // 5: wrong flowid and wrong type are dropped while waiting; correct flit completes.
    @(negedge clk);
    chk1("t5_err_clear", err_unexp_flit, 1'b0);
    tick();
    issue_read(8'd3, tgt);
    wait_flits(tgt);
    tick();
    send_ctovr(resp_flit(TCP_RX_PTRS_RESP, 8'd9, 32'h1, 32'h2));
    @(negedge clk);
    chk1("t5_err_set", err_unexp_flit, 1'b1);
    chk1("t5_no_resp", app_rd_resp_val, 1'b0);
    chk1("t5_still_waiting", noc0_ctovr_rdy, 1'b1);
    tick();
    send_ctovr(resp_flit(TCP_RX_PTRS_REQ, 8'd3, 32'h1, 32'h2));
    @(negedge clk);
    chk1("t5_wrong_type_no_resp", app_rd_resp_val, 1'b0);
    tick();
    finish_read(8'd3, 32'h55, 32'h66, tgt);
    @(negedge clk);
    chk1("t5_err_sticky", err_unexp_flit, 1'b1);
    tick();

    // 6: reset during WAIT_RESP; late response is dropped in IDLE.
    do_reset();
    @(negedge clk);
    chk1("t6_err_cleared", err_unexp_flit, 1'b0);
    tick();
    issue_read(8'd3, tgt);
    wait_flits(tgt);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk1("t6_ctovr_rdy_in_rst", noc0_ctovr_rdy, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("t6_idle_after_rst", app_wr_req_rdy, 1'b1);
    tick();
    send_ctovr(resp_flit(TCP_RX_PTRS_RESP, 8'd3, 32'h77, 32'h88));
    @(negedge clk);
    chk1("t6_late_err", err_unexp_flit, 1'b1);
    chk1("t6_late_no_resp", app_rd_resp_val, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    chk1("t6_still_no_resp", app_rd_resp_val, 1'b0);
    tick();

    // Random traffic with random backpressure on both sides.
    do_reset();
    bp_mode = 1;
    rr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      f = 8'($urandom);
      h = $urandom;
      c = $urandom;
      if ($urandom_range(1) == 0) begin
        do_write(f, h);
      end else begin
        issue_read(f, tgt);
        finish_read(f, h, c, tgt);
      end
    end
    bp_mode = 0;
    rr_mode = 0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk64("rand_flits_drained", 64'(exp_flit_q.size()), 64'd0);
    chk64("rand_resps_drained", 64'(exp_resp_q.size()), 64'd0);
    chk1("rand_no_err", err_unexp_flit, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
